apb_master_bridge: RTL and testbench

//  Requester end of the APB bus: turns a valid/ready command from a local controller into one
//  APB transfer (SETUP, then ACCESS) aimed at peripherals such as the GPIO block.

---
 rtl/apb_master_bridge_pkg.sv | 15 +
 rtl/apb_master_bridge_if.sv | 48 ++++
 rtl/apb_master_bridge_wait_timer.sv | 34 +++
 rtl/apb_master_bridge.sv | 138 +++++++++++++
 tb/tb_apb_master_bridge.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_bridge_pkg.sv
// Purpose: shared definitions for the APB requester bridge.
//   apb_state_t : transfer FSM encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3)
//   PSTRB_READ  : strobe bit value driven on the bus during reads
package apb_master_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

  localparam logic PSTRB_READ = 1'b0;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Purpose: bundles the command/response handshake and the APB bus of the
// requester bridge.
//   master modport : bridge side (drives cmd_ready, rsp_*, APB_P* requests)
//   slave modport  : environment side (local controller plus APB completer)
interface apb_master_bridge_if #(
  parameter int PDATA_SIZE = 32,
  parameter int PADDR_SIZE = 4
);
  localparam int PSTRB_SIZE = PDATA_SIZE / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [PADDR_SIZE-1:0] cmd_addr;
  logic [PDATA_SIZE-1:0] cmd_wdata;
  logic [PSTRB_SIZE-1:0] cmd_strb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [PDATA_SIZE-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  APB_PSEL;
  logic                  APB_PENABLE;
  logic [PADDR_SIZE-1:0] APB_PADDR;
  logic                  APB_PWRITE;
  logic [PSTRB_SIZE-1:0] APB_PSTRB;
  logic [PDATA_SIZE-1:0] APB_PWDATA;
  logic [PDATA_SIZE-1:0] APB_PRDATA;
  logic                  APB_PREADY;
  logic                  APB_PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           APB_PRDATA, APB_PREADY, APB_PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           APB_PSEL, APB_PENABLE, APB_PADDR, APB_PWRITE, APB_PSTRB, APB_PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           APB_PRDATA, APB_PREADY, APB_PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           APB_PSEL, APB_PENABLE, APB_PADDR, APB_PWRITE, APB_PSTRB, APB_PWDATA
  );

endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// Purpose: saturating wait-state counter with an expired flag at TIMEOUT.
//   APB_CLK, APB_RESET : clock, async active-high reset
//   clear              : synchronous clear (start of a transfer)
//   enable             : count one wait cycle
//   expired            : count has reached TIMEOUT; never set when TIMEOUT=0
module apb_master_bridge_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic APB_CLK,
  input  logic APB_RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // With the timer disabled the counter just parks at all-ones.
  localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT) : {CW{1'b1}};

  logic [CW-1:0] count;

  always_ff @(posedge APB_CLK or posedge APB_RESET) begin
    if (APB_RESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT > 0) && (count == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// Purpose: APB requester. Accepts one valid/ready command, runs a single
// SETUP+ACCESS transfer, and returns a held response. A wait-state timer
// aborts transfers to slaves that never raise PREADY.
//   APB_CLK   : bus clock
//   APB_RESET : async active-high reset
//   bus       : command/response handshake and APB signals (master modport)
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int PDATA_SIZE = 32,
  parameter int PADDR_SIZE = 4,
  parameter int TIMEOUT    = 16
) (
  input logic                 APB_CLK,
  input logic                 APB_RESET,
  apb_master_bridge_if.master bus
);

  localparam int PSTRB_SIZE = PDATA_SIZE / 8;

  apb_state_t state, state_nxt;

  logic [PADDR_SIZE-1:0] paddr_q;
  logic                  pwrite_q;
  logic [PSTRB_SIZE-1:0] pstrb_q;
  logic [PDATA_SIZE-1:0] pwdata_q;
  logic [PDATA_SIZE-1:0] rdata_q;
  logic                  err_q;
  logic                  tmo_q;

  logic accept;
  logic in_access;
  logic wait_cycle;
  logic expired;

  logic cmd_ready_c;
  logic psel_c;
  logic penable_c;
  logic rsp_valid_c;

  assign accept     = (state == ST_IDLE) && bus.cmd_valid;
  assign in_access  = (state == ST_ACCESS);
  assign wait_cycle = in_access && !bus.APB_PREADY;

  apb_master_bridge_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .APB_CLK   (APB_CLK),
    .APB_RESET (APB_RESET),
    .clear     (accept),
    .enable    (wait_cycle),
    .expired   (expired)
  );

  always_ff @(posedge APB_CLK or posedge APB_RESET) begin
    if (APB_RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (bus.cmd_valid) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      // PREADY is checked first so a slave answering in the expiry cycle wins.
      ST_ACCESS: if (bus.APB_PREADY || expired) state_nxt = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_c = 1'b0;
    psel_c      = 1'b0;
    penable_c   = 1'b0;
    rsp_valid_c = 1'b0;
    unique case (state)
      // Reset parks the FSM in IDLE; keep cmd_ready low while reset is held.
      ST_IDLE:   cmd_ready_c = !APB_RESET;
      ST_SETUP:  psel_c      = 1'b1;
      ST_ACCESS: begin
        psel_c    = 1'b1;
        penable_c = 1'b1;
      end
      ST_RESP:   rsp_valid_c = 1'b1;
      default:   cmd_ready_c = 1'b0;
    endcase
  end

  always_ff @(posedge APB_CLK or posedge APB_RESET) begin
    if (APB_RESET) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= '0;
      pwdata_q <= '0;
    end else if (accept) begin
      paddr_q  <= bus.cmd_addr;
      pwrite_q <= bus.cmd_write;
      pstrb_q  <= bus.cmd_write ? bus.cmd_strb : {PSTRB_SIZE{PSTRB_READ}};
      // Reads leave the previous write data on PWDATA.
      if (bus.cmd_write) pwdata_q <= bus.cmd_wdata;
    end
  end

  always_ff @(posedge APB_CLK or posedge APB_RESET) begin
    if (APB_RESET) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else if (in_access) begin
      if (bus.APB_PREADY) begin
        rdata_q <= pwrite_q ? '0 : bus.APB_PRDATA;
        err_q   <= bus.APB_PSLVERR;
        tmo_q   <= 1'b0;
      end else if (expired) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        tmo_q   <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready   = cmd_ready_c;
  assign bus.rsp_valid   = rsp_valid_c;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = tmo_q;
  assign bus.APB_PSEL    = psel_c;
  assign bus.APB_PENABLE = penable_c;
  assign bus.APB_PADDR   = paddr_q;
  assign bus.APB_PWRITE  = pwrite_q;
  assign bus.APB_PSTRB   = pstrb_q;
  assign bus.APB_PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  localparam int TIMEOUT = 16;

  logic APB_CLK   = 1'b0;
  logic APB_RESET = 1'b1;

  always #5 APB_CLK = ~APB_CLK;

  apb_master_bridge_if #(.PDATA_SIZE(32), .PADDR_SIZE(4)) bus ();

  apb_master_bridge #(
    .PDATA_SIZE (32),
    .PADDR_SIZE (4),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .APB_CLK   (APB_CLK),
    .APB_RESET (APB_RESET),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Completer model: holds PREADY low for slv_waits ACCESS cycles, and drives
  // junk on PREADY/PSLVERR/PRDATA whenever no ACCESS phase is on the bus.
  int          acc_cnt;
  int          slv_waits;
  logic        slv_err;
  logic [31:0] slv_rdata;
  logic        junk_rdy, junk_err;
  logic [31:0] junk_data;
  logic        in_acc;

  assign in_acc          = bus.APB_PSEL && bus.APB_PENABLE;
  assign bus.APB_PREADY  = in_acc ? (acc_cnt >= slv_waits) : junk_rdy;
  assign bus.APB_PSLVERR = in_acc ? slv_err : junk_err;
  assign bus.APB_PRDATA  = in_acc ? slv_rdata : junk_data;

  always @(posedge APB_CLK or posedge APB_RESET) begin
    if (APB_RESET) acc_cnt <= 0;
    else if (in_acc) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  // Expected PWDATA: data of the most recent accepted write since reset.
  logic [31:0] last_wdata;

  int          obs_lat, obs_psel, obs_pen;
  logic        obs_bus_ok, obs_ready_ok, obs_hold_ok, obs_resp_sel, obs_released;
  logic [31:0] obs_rdata;
  logic        obs_err, obs_tmo;

  task automatic step();
    @(posedge APB_CLK);
    #1;
    cyc++;
    junk_rdy  = 1'($urandom);
    junk_err  = 1'($urandom);
    junk_data = $urandom;
  endtask

  // Drives one command, watches the bus until the response, holds rsp_ready
  // low for 'hold' cycles, then consumes the response. Latency is counted in
  // edges from the accepting edge (accept edge = 1).
  task automatic run_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input int waits, input logic err,
                          input logic [31:0] rd, input int hold);
    logic        accepted;
    logic [3:0]  exp_strb;
    logic [31:0] h_rd;
    logic        h_err, h_tmo;
    int          edges;
    slv_waits = waits; slv_err = err; slv_rdata = rd;
    bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wd; bus.cmd_strb = st;
    bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b0;
    obs_lat = 0; obs_psel = 0; obs_pen = 0;
    obs_bus_ok = 1'b1; obs_ready_ok = 1'b1; obs_hold_ok = 1'b1;
    obs_resp_sel = 1'b1; obs_released = 1'b0;
    obs_rdata = 32'hDEAD_DEAD; obs_err = 1'bx; obs_tmo = 1'bx;
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (bus.cmd_ready) accepted = 1'b1;
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom); bus.cmd_addr = 4'($urandom);
    bus.cmd_wdata = $urandom; bus.cmd_strb = 4'($urandom);
    if (!accepted) return;
    if (wr) last_wdata = wd;
    exp_strb = wr ? st : 4'h0;
    edges = 1;
    while (!bus.rsp_valid && edges < 100) begin
      if (bus.APB_PSEL) begin
        obs_psel++;
        if (bus.APB_PADDR !== addr || bus.APB_PWRITE !== wr ||
            bus.APB_PSTRB !== exp_strb || bus.APB_PWDATA !== last_wdata) obs_bus_ok = 1'b0;
      end
      if (bus.APB_PENABLE) obs_pen++;
      if (bus.cmd_ready) obs_ready_ok = 1'b0;
      step();
      edges++;
    end
    if (!bus.rsp_valid) return;
    obs_lat      = edges;
    obs_rdata    = bus.rsp_rdata;
    obs_err      = bus.rsp_err;
    obs_tmo      = bus.rsp_timeout;
    obs_resp_sel = bus.APB_PSEL | bus.APB_PENABLE;
    h_rd = bus.rsp_rdata; h_err = bus.rsp_err; h_tmo = bus.rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      step();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== h_rd || bus.rsp_err !== h_err ||
          bus.rsp_timeout !== h_tmo || bus.cmd_ready !== 1'b0 || bus.APB_PSEL !== 1'b0)
        obs_hold_ok = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    obs_released = !bus.rsp_valid && bus.cmd_ready;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout,
         bus.APB_PSEL, bus.APB_PENABLE, bus.APB_PWRITE} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {bus.cmd_ready, bus.rsp_valid,
               bus.rsp_err, bus.rsp_timeout, bus.APB_PSEL, bus.APB_PENABLE, bus.APB_PWRITE});
    end
    n_checks++;
    if ({bus.APB_PADDR, bus.APB_PSTRB, bus.APB_PWDATA, bus.rsp_rdata} !== 72'h0) begin
      n_errors++;
      $display("FAIL reset_data: got %h expected 0",
               {bus.APB_PADDR, bus.APB_PSTRB, bus.APB_PWDATA, bus.rsp_rdata});
    end
    step();
    APB_RESET = 1'b0;
    last_wdata = 32'h0;
    step();
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL ready_after_reset: got %b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write_basic();
    run_xfer(1'b1, 4'h1, 32'hA5A5_0F0F, 4'hF, 0, 1'b0, 32'h7777_7777, 0);
    n_checks++; if (obs_lat !== 3) begin n_errors++; $display("FAIL wr_latency: got %0d expected 3", obs_lat); end
    n_checks++; if (obs_psel !== 2) begin n_errors++; $display("FAIL wr_psel_cycles: got %0d expected 2", obs_psel); end
    n_checks++; if (obs_pen !== 1) begin n_errors++; $display("FAIL wr_penable_cycles: got %0d expected 1", obs_pen); end
    n_checks++; if ({obs_err, obs_tmo} !== 2'b00) begin n_errors++; $display("FAIL wr_err: got %b expected 00", {obs_err, obs_tmo}); end
    n_checks++; if (obs_rdata !== 32'h0) begin n_errors++; $display("FAIL wr_rdata: got %h expected 0", obs_rdata); end
    n_checks++; if (obs_bus_ok !== 1'b1 || obs_ready_ok !== 1'b1) begin n_errors++; $display("FAIL wr_bus: got bus %b ready %b expected 1 1", obs_bus_ok, obs_ready_ok); end
    n_checks++; if (obs_released !== 1'b1) begin n_errors++; $display("FAIL wr_release: got %b expected 1", obs_released); end
  endtask

  task automatic test_read_wait();
    run_xfer(1'b0, 4'h3, 32'h1111_2222, 4'hF, 3, 1'b0, 32'h1234_5678, 0);
    n_checks++; if (obs_lat !== 6) begin n_errors++; $display("FAIL rd_latency: got %0d expected 6", obs_lat); end
    n_checks++; if (obs_pen !== 4) begin n_errors++; $display("FAIL rd_access_cycles: got %0d expected 4", obs_pen); end
    n_checks++; if (obs_rdata !== 32'h1234_5678) begin n_errors++; $display("FAIL rd_rdata: got %h expected 12345678", obs_rdata); end
    n_checks++; if (obs_bus_ok !== 1'b1) begin n_errors++; $display("FAIL rd_bus_strb_hold: got %b expected 1", obs_bus_ok); end
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 4'h5, 32'h0, 4'h0, 1000, 1'b0, 32'h5555_AAAA, 0);
    n_checks++; if (obs_lat !== 3 + TIMEOUT) begin n_errors++; $display("FAIL tmo_latency: got %0d expected %0d", obs_lat, 3 + TIMEOUT); end
    n_checks++; if ({obs_err, obs_tmo} !== 2'b11) begin n_errors++; $display("FAIL tmo_flags: got %b expected 11", {obs_err, obs_tmo}); end
    n_checks++; if (obs_rdata !== 32'h0) begin n_errors++; $display("FAIL tmo_rdata: got %h expected 0", obs_rdata); end
    n_checks++; if (obs_resp_sel !== 1'b0) begin n_errors++; $display("FAIL tmo_psel_in_resp: got %b expected 0", obs_resp_sel); end
    // PREADY rises in the very cycle the counter reaches TIMEOUT.
    run_xfer(1'b0, 4'h6, 32'h0, 4'h0, TIMEOUT, 1'b0, 32'hBEEF_0016, 0);
    n_checks++; if (obs_lat !== 3 + TIMEOUT) begin n_errors++; $display("FAIL edge_latency: got %0d expected %0d", obs_lat, 3 + TIMEOUT); end
    n_checks++; if ({obs_err, obs_tmo} !== 2'b00) begin n_errors++; $display("FAIL edge_flags: got %b expected 00", {obs_err, obs_tmo}); end
    n_checks++; if (obs_rdata !== 32'hBEEF_0016) begin n_errors++; $display("FAIL edge_rdata: got %h expected beef0016", obs_rdata); end
  endtask

  task automatic test_slverr_hold();
    run_xfer(1'b1, 4'hA, 32'h0F0F_1234, 4'h5, 0, 1'b1, 32'h0, 5);
    n_checks++; if ({obs_err, obs_tmo} !== 2'b10) begin n_errors++; $display("FAIL slverr_flags: got %b expected 10", {obs_err, obs_tmo}); end
    n_checks++; if (obs_hold_ok !== 1'b1) begin n_errors++; $display("FAIL slverr_hold_stable: got %b expected 1", obs_hold_ok); end
    n_checks++; if (obs_released !== 1'b1) begin n_errors++; $display("FAIL slverr_release: got %b expected 1", obs_released); end
  endtask

  task automatic test_async_reset();
    slv_waits = 1000; slv_err = 1'b0;
    bus.cmd_write = 1'b0; bus.cmd_addr = 4'h2; bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    n_checks++; if ({bus.APB_PSEL, bus.APB_PENABLE} !== 2'b11) begin n_errors++; $display("FAIL arst_in_access: got %b expected 11", {bus.APB_PSEL, bus.APB_PENABLE}); end
    #2 APB_RESET = 1'b1;
    #1;
    n_checks++;
    if ({bus.APB_PSEL, bus.APB_PENABLE, bus.rsp_valid, bus.cmd_ready} !== 4'b0) begin
      n_errors++;
      $display("FAIL arst_drop: got %b expected 0000", {bus.APB_PSEL, bus.APB_PENABLE, bus.rsp_valid, bus.cmd_ready});
    end
    step();
    APB_RESET = 1'b0;
    last_wdata = 32'h0;
    step();
    run_xfer(1'b1, 4'h9, 32'hCAFE_0001, 4'h3, 1, 1'b0, 32'h0, 0);
    n_checks++; if (obs_lat !== 4) begin n_errors++; $display("FAIL arst_after_latency: got %0d expected 4", obs_lat); end
    n_checks++; if (obs_bus_ok !== 1'b1 || obs_err !== 1'b0) begin n_errors++; $display("FAIL arst_after_bus: got bus %b err %b expected 1 0", obs_bus_ok, obs_err); end
    run_xfer(1'b0, 4'h6, 32'h0, 4'hF, 0, 1'b0, 32'h0BAD_F00D, 0);
    n_checks++; if (obs_rdata !== 32'h0BAD_F00D || obs_bus_ok !== 1'b1) begin n_errors++; $display("FAIL arst_after_read: got %h bus %b expected 0badf00d 1", obs_rdata, obs_bus_ok); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  a [4];
    logic        w [4];
    logic [31:0] d [4];
    int          acc [4];
    int          idx, cur, rsp_cnt, bad;
    logic        took;
    for (int i = 0; i < 4; i++) begin
      a[i] = 4'($urandom); w[i] = (i % 2 == 0); d[i] = $urandom; acc[i] = 0;
    end
    slv_waits = 0; slv_err = 1'b0; bus.rsp_ready = 1'b1;
    idx = 0; cur = 0; rsp_cnt = 0; bad = 0;
    bus.cmd_write = w[0]; bus.cmd_addr = a[0]; bus.cmd_wdata = d[0]; bus.cmd_strb = 4'hF;
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 60 && rsp_cnt < 4; c++) begin
      took = 1'b0;
      if (bus.rsp_valid) rsp_cnt++;
      if (bus.APB_PSEL && (idx == 0 || bus.APB_PADDR !== a[cur] || bus.APB_PWRITE !== w[cur] ||
                           bus.APB_PWDATA !== last_wdata)) bad++;
      if (bus.cmd_ready && bus.APB_PSEL) bad++;
      if (bus.cmd_ready && bus.cmd_valid && idx < 4) begin
        acc[idx] = cyc; cur = idx;
        if (w[idx]) last_wdata = d[idx];
        idx++; took = 1'b1;
      end
      step();
      if (took) begin
        if (idx < 4) begin
          bus.cmd_write = w[idx]; bus.cmd_addr = a[idx]; bus.cmd_wdata = d[idx];
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    n_checks++; if (idx !== 4 || rsp_cnt !== 4) begin n_errors++; $display("FAIL b2b_count: got acc %0d rsp %0d expected 4 4", idx, rsp_cnt); end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL b2b_bus_stable: got %0d violations expected 0", bad); end
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (acc[i] - acc[i-1] !== 4) begin n_errors++; $display("FAIL b2b_spacing%0d: got %0d expected 4", i, acc[i] - acc[i-1]); end
    end
  endtask

  task automatic test_random();
    logic        wr, er, tmo_exp;
    logic [3:0]  ad, st;
    logic [31:0] wd, rd, rdata_exp;
    int          wt, hold, lat_exp;
    for (int n = 0; n < 25; n++) begin
      wr = 1'($urandom); ad = 4'($urandom); st = 4'($urandom);
      wd = $urandom; rd = $urandom;
      wt = ($urandom_range(0, 6) == 0) ? int'($urandom_range(17, 22)) : int'($urandom_range(0, 16));
      er = ($urandom_range(0, 3) == 0);
      hold = int'($urandom_range(0, 3));
      run_xfer(wr, ad, wd, st, wt, er, rd, hold);
      tmo_exp   = (wt > TIMEOUT);
      lat_exp   = 3 + (tmo_exp ? TIMEOUT : wt);
      rdata_exp = (wr || tmo_exp) ? 32'h0 : rd;
      n_checks++;
      if (obs_lat !== lat_exp || obs_psel !== lat_exp - 1 || obs_pen !== lat_exp - 2) begin
        n_errors++;
        $display("FAIL rnd%0d_timing: got lat %0d psel %0d pen %0d expected lat %0d", n, obs_lat, obs_psel, obs_pen, lat_exp);
      end
      n_checks++;
      if (obs_rdata !== rdata_exp || obs_err !== (er | tmo_exp) || obs_tmo !== tmo_exp) begin
        n_errors++;
        $display("FAIL rnd%0d_resp: got %h/%b/%b expected %h/%b/%b", n, obs_rdata, obs_err, obs_tmo, rdata_exp, er | tmo_exp, tmo_exp);
      end
      n_checks++;
      if (obs_bus_ok !== 1'b1 || obs_ready_ok !== 1'b1 || obs_hold_ok !== 1'b1 || obs_released !== 1'b1) begin
        n_errors++;
        $display("FAIL rnd%0d_protocol: got bus %b ready %b hold %b rel %b expected 1111", n, obs_bus_ok, obs_ready_ok, obs_hold_ok, obs_released);
      end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 4'h0;
    bus.cmd_wdata = 32'h0; bus.cmd_strb = 4'h0; bus.rsp_ready = 1'b0;
    slv_waits = 0; slv_err = 1'b0; slv_rdata = 32'h0;
    junk_rdy = 1'b0; junk_err = 1'b0; junk_data = 32'h0;
    last_wdata = 32'h0;
    test_reset();
    test_write_basic();
    test_read_wait();
    test_timeout();
    test_slverr_hold();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
